instr_encoder: RTL and testbench
================================

# instr_encoder

Assembles RV32I instruction words from field tuples and writes them sequentially into instruction memory. It is the write-side counterpart of the decoder: it packs opcode, register indices, funct fields and an immediate into the encoding the decoder unpacks. It sits between the testbench or debug program-load path and the instruction memory write port, and owns the load address counter.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width.
- `DEPTH`, 256: number of words to load before the block reports full; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous; address counter to 0, `err` cleared, state to IDLE.
- `in_valid`  in  1  field tuple valid.
- `in_ready`  out  1  tuple accepted when `in_valid && in_ready`.
- `opcode`  in  7  instruction opcode.
- `funct3`  in  3  funct3 field.
- `funct7`  in  7  funct7 field.
- `rd`, `rs1`, `rs2`  in  5 each  register indices.
- `imm`  in  32  immediate, in the unpacked value the decoder produces.
- `imem_we`  out  1  write request to instruction memory.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `imem_ack`  in  1  memory accepted the write this cycle.
- `word_count`  out  ADDR_W+1  words written since reset or `clear`.
- `full`  out  1  `DEPTH` words written.
- `err`  out  1  sticky; an unsupported opcode was seen (see Configuration for extra causes).

## Operation
FSM states:
- IDLE: `in_ready`=1. On accept, register the encoded word and move to WRITE.
- WRITE: `imem_we`=1, with `imem_addr` and `imem_wdata` held stable. On `imem_ack`: increment the address and `word_count`. Go to FULL if `word_count` reaches `DEPTH`, otherwise go to IDLE.
- FULL: `in_ready`=0 and `full`=1. Leave only on `clear` or `rst`.

Packing by opcode:
- R (0110011): funct7, rs2, rs1, funct3, rd, opcode.
- I (0010011), load (0000011), JALR (1100111): imm[11:0] goes to [31:20].
  - Exception: for 0010011 with funct3 001 or 101, [31:25]=funct7 and [24:20]=imm[4:0].
- S (0100011): imm[11:5] to [31:25], imm[4:0] to [11:7].
- B (1100011): imm[12] to 31, imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to 7. imm[0] is ignored.
- U (LUI 0110111, AUIPC 0010111): imm[31:12] to [31:12].
- J (1101111): imm[20] to 31, imm[10:1] to [30:21], imm[11] to 20, imm[19:12] to [19:12].
- Register and funct fields are used only where the format contains them. Unused fields are ignored.

Other rules:
- Any other opcode: write NOP 0x00000013 and set `err`. The address still advances.
- `clear` takes priority over a handshake in the same cycle. A pending WRITE word is discarded.
- The address wraps only through `clear`. No writes occur in FULL.

## Timing
- Reset values: state IDLE, `in_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `word_count`=0, `full`=0, `err`=0.
- Latency: a tuple accepted at edge N gives `imem_we`=1 with valid data after edge N. With `imem_ack` high, writes complete at edge N+1.
- Throughput: one word per 2 cycles at best; `in_ready` is 0 throughout WRITE.
- `imem_ack` low stalls WRITE indefinitely. The outputs stay stable during the stall.
- `rst` asserted mid-WRITE: `imem_we` deasserts immediately (asynchronously) and the word is lost.
- `full` rises on the same edge as the last write completes.

## Configuration
- `ENCODER_IMM_CHECK_EN` defined: the immediate must be representable, checked per format:
  - I/S: −2048..2047.
  - B: −4096..4094, even.
  - J: ±1 MiB range, even.
  - U: imm[11:0]=0.
  - Shift immediates: imm[31:5]=0.
  - On violation: write NOP 0x00000013 and set `err`.
- Undefined: the immediate is silently truncated to its field. `err` is set only for unsupported opcodes.

## Test plan
- add x3,x1,x2 (opcode 0x33, f3 0, f7 0, rd 3, rs1 1, rs2 2) with `imem_ack` tied high → addr 0, wdata 0x002081B3, `word_count`=1, two cycles from accept to IDLE.
- addi x5,x0,−1 (imm 0xFFFFFFFF) then sw x2,8(x1) (f3 010) → 0xFFF00293 at addr 0, 0x0020A423 at addr 1.
- beq x0,x0,−4 (imm 0xFFFFFFFC) → 0xFE000EE3. Hold `imem_ack` low 5 cycles first → `imem_we`, addr and data stable throughout, `in_ready`=0.
- opcode 0x7F → 0x00000013 written, `err`=1 and stays set across following valid tuples until `clear`.
- `DEPTH`=4, stream 5 tuples → `full`=1 after the 4th ack, 5th tuple not accepted. `clear` → addr 0, `full`=0, and the 5th tuple is written at addr 0.
- With `ENCODER_IMM_CHECK_EN`: addi imm 4096 → NOP and `err`=1. Without it: wdata 0x00000013 | (rd<<7), i.e. the truncated imm is 0 and `err`=0.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field tuples into instruction words and writes them to imem.
// Optional ENCODER_IMM_CHECK_EN rejects immediates that do not fit their format (writes NOP, sets err).
//
// state | meaning
// IDLE  | ready for a field tuple
// WRITE | holding an encoded word on the imem write port until imem_ack
// FULL  | DEPTH words written; waits for clear
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [31:0]         enc_raw, enc_word;
  logic                enc_unsup, enc_bad;
  logic                is_shift;

  assign is_shift = (opcode == OP_IMM) && (funct3 == 3'b001 || funct3 == 3'b101);

  always_comb begin
    enc_raw   = NOP;
    enc_unsup = 1'b0;
    case (opcode)
      OP_R:    enc_raw = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_IMM, OP_LOAD, OP_JALR:
        if (is_shift) enc_raw = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else          enc_raw = {imm[11:0], rs1, funct3, rd, opcode};
      OP_STORE:  enc_raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OP_BRANCH: enc_raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OP_LUI, OP_AUIPC: enc_raw = {imm[31:12], rd, opcode};
      OP_JAL:  enc_raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_unsup = 1'b1;
    endcase
  end

`ifdef ENCODER_IMM_CHECK_EN
  logic imm_ok;

  // Signed range checks: all bits above the field's sign bit must equal it.
  always_comb begin
    imm_ok = 1'b1;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        if (is_shift) imm_ok = (imm[31:5] == 27'd0);
        else          imm_ok = (&imm[31:11]) || (~|imm[31:11]);
      OP_STORE:  imm_ok = (&imm[31:11]) || (~|imm[31:11]);
      OP_BRANCH: imm_ok = ((&imm[31:12]) || (~|imm[31:12])) && !imm[0];
      OP_LUI, OP_AUIPC: imm_ok = (imm[11:0] == 12'd0);
      OP_JAL:    imm_ok = ((&imm[31:20]) || (~|imm[31:20])) && !imm[0];
      default:   imm_ok = 1'b1;
    endcase
  end

  assign enc_bad  = enc_unsup || !imm_ok;
`else
  assign enc_bad  = enc_unsup;
`endif
  assign enc_word = enc_bad ? NOP : enc_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    full     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = WRITE;
      end
      WRITE: begin
        imem_we = 1'b1;
        if (imem_ack) state_nx = (count_q + 1'b1 == DEPTH_C) ? FULL : IDLE;
      end
      FULL:    full = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        wdata_q <= enc_word;
        if (enc_bad) err_q <= 1'b1;
      end
      if (state == WRITE && imem_ack) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4): vector table plus hand sequences for stall,
// sticky err, full/clear, and reset/clear during WRITE.
module tb_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        opcode = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0]       imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack = 1'b1;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              err;

  int errors = 0;
  int checks = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .word_count(word_count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_w;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];
  vec_t v_addi, v_sw, v_beq, v_bad, v_add, v_sub;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Caller is just after a negedge; holds the tuple until it is accepted (bounded).
  task automatic send(input vec_t v);
    bit ok;
    ok = 0;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout %s: in_ready never rose, got 0 expected 1", v.name);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"add",   7'h33, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 32'h002081B3, 1'b0};
    vecs[1]  = '{"sub",   7'h33, 3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0,        32'h402081B3, 1'b0};
    vecs[2]  = '{"addi",  7'h13, 3'b000, 7'h7F, 5'd5, 5'd0, 5'd9, 32'hFFFFFFFF, 32'hFFF00293, 1'b0};
    vecs[3]  = '{"sw",    7'h23, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0};
    vecs[4]  = '{"beq",   7'h63, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    vecs[5]  = '{"lui",   7'h37, 3'b111, 7'h7F, 5'd1, 5'd31,5'd31,32'h12345000, 32'h123450B7, 1'b0};
    vecs[6]  = '{"auipc", 7'h17, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF117, 1'b0};
    vecs[7]  = '{"jal+",  7'h6F, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 1'b0};
    vecs[8]  = '{"jal-",  7'h6F, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFF9FF06F, 1'b0};
    vecs[9]  = '{"jalr",  7'h67, 3'b000, 7'h00, 5'd1, 5'd5, 5'd0, 32'd4,        32'h004280E7, 1'b0};
    vecs[10] = '{"lw",    7'h03, 3'b010, 7'h00, 5'd6, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC12303, 1'b0};
    vecs[11] = '{"srai",  7'h13, 3'b101, 7'h20, 5'd4, 5'd4, 5'd0, 32'd31,       32'h41F25213, 1'b0};
`ifdef ENCODER_IMM_CHECK_EN
    vecs[12] = '{"addi4096", 7'h13, 3'b000, 7'h00, 5'd7, 5'd0, 5'd0, 32'd4096, 32'h00000013, 1'b1};
`else
    vecs[12] = '{"addi4096", 7'h13, 3'b000, 7'h00, 5'd7, 5'd0, 5'd0, 32'd4096, 32'h00000393, 1'b0};
`endif
    v_addi = vecs[2];
    v_sw   = vecs[3];
    v_beq  = vecs[4];
    v_add  = vecs[0];
    v_sub  = vecs[1];
    v_bad  = '{"bad", 7'h7F, 3'b000, 7'h00, 5'd1, 5'd1, 5'd1, 32'h0, 32'h00000013, 1'b1};

    // reset state
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", word_count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 1'b0;

    // table vectors, one per clear so DEPTH is never reached
    for (int i = 0; i < 13; i++) begin
      pulse_clear();
      send(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_we"}, imem_we, 1);
      chk({vecs[i].name, "_addr"}, imem_addr, 0);
      chk({vecs[i].name, "_wdata"}, imem_wdata, vecs[i].exp_w);
      @(negedge clk);
      chk({vecs[i].name, "_idle"}, in_ready, 1);
      chk({vecs[i].name, "_count"}, word_count, 1);
      chk({vecs[i].name, "_err"}, err, vecs[i].exp_err);
    end

    // back-to-back addi then sw
    pulse_clear();
    send(v_addi);
    @(negedge clk);
    chk("seq_addr0", imem_addr, 0);
    chk("seq_wdata0", imem_wdata, 32'hFFF00293);
    send(v_sw);
    @(negedge clk);
    chk("seq_addr1", imem_addr, 1);
    chk("seq_wdata1", imem_wdata, 32'h0020A423);
    @(negedge clk);
    chk("seq_count", word_count, 2);

    // ack stall: outputs hold
    pulse_clear();
    imem_ack = 1'b0;
    send(v_beq);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_we", imem_we, 1);
      chk("stall_addr", imem_addr, 0);
      chk("stall_wdata", imem_wdata, 32'hFE000EE3);
      chk("stall_ready", in_ready, 0);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    chk("stall_done_count", word_count, 1);
    chk("stall_done_we", imem_we, 0);

    // unsupported opcode, err sticky until clear
    pulse_clear();
    send(v_bad);
    @(negedge clk);
    chk("bad_wdata", imem_wdata, 32'h00000013);
    @(negedge clk);
    chk("bad_err", err, 1);
    chk("bad_count", word_count, 1);
    send(v_add);
    @(negedge clk);
    chk("sticky_wdata", imem_wdata, 32'h002081B3);
    @(negedge clk);
    chk("sticky_err", err, 1);
    pulse_clear();
    chk("clear_err", err, 0);

    // fill to DEPTH, fifth tuple blocked until clear
    for (int k = 0; k < DEPTH; k++) begin
      send(v_add);
      @(negedge clk);
      chk("fill_addr", imem_addr, k);
      chk("fill_full_pre", full, 0);
    end
    @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_count", word_count, DEPTH);
    opcode = v_sub.op; funct3 = v_sub.f3; funct7 = v_sub.f7;
    rd = v_sub.rd; rs1 = v_sub.rs1; rs2 = v_sub.rs2; imm = v_sub.imm;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_ready", in_ready, 0);
      chk("full_we", imem_we, 0);
    end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_full", full, 0);
    chk("clr_addr", imem_addr, 0);
    chk("clr_count", word_count, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("fifth_we", imem_we, 1);
    chk("fifth_addr", imem_addr, 0);
    chk("fifth_wdata", imem_wdata, 32'h402081B3);
    @(negedge clk);
    chk("fifth_count", word_count, 1);

    // clear during WRITE discards the word
    pulse_clear();
    imem_ack = 1'b0;
    send(v_add);
    @(negedge clk);
    chk("cw_we", imem_we, 1);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("cw_we_after", imem_we, 0);
    chk("cw_ready", in_ready, 1);
    chk("cw_count", word_count, 0);
    imem_ack = 1'b1;

    // async reset mid-WRITE
    imem_ack = 1'b0;
    send(v_add);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", imem_we, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_count", word_count, 0);
    @(negedge clk); rst = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    chk("arst_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
